synaptic_input_processor: RTL and testbench

Front end plus leaky integrate-and-fire (LIF) core for one neuron with 16 presynaptic inputs. Each sweep it captures a 16-bit spike vector and a 16-bit excitatory/inhibitory vector. It then walks the synapses one per cycle, adding or subtracting 4-bit weights from an internal weight file into a membrane potential. At the end of the sweep it applies leak and the threshold compare, emits a spike, and pulses flush requests so the upstream feeder supplies the next vectors.

---
 rtl/synaptic_input_processor.sv | 131 +++++++++++++
 tb/tb_synaptic_input_processor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/synaptic_input_processor.sv
`default_nettype none
// ============================================================================
// Module   : synaptic_input_processor
// Brief    : 16-input synaptic front end with a leaky integrate-and-fire core.
// Revision : 1.0
// ============================================================================
module synaptic_input_processor #(
    parameter int N_SYN     = 16,
    parameter int W_WIDTH   = 4,
    parameter int V_WIDTH   = 8,
    parameter int THRESHOLD = 40,
    parameter int LEAK      = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write,
    input  logic                       ST_and,
    input  logic                       CT_and,
    input  logic                       ST,
    input  logic                       CT,
    input  logic [N_SYN-1:0]           parallel_spike_in,
    input  logic [N_SYN-1:0]           parallel_Ein,
    output logic                       flush_weight,
    output logic                       flush_Ein,
    output logic                       flush_spike,
    output logic                       spike,
    output logic [$clog2(N_SYN)-1:0]   select
);

    localparam int SEL_W = $clog2(N_SYN);
    localparam logic [SEL_W-1:0]   C_LAST      = SEL_W'(N_SYN - 1);
    localparam logic [V_WIDTH-1:0] C_LEAK      = V_WIDTH'(LEAK);
    localparam logic [V_WIDTH-1:0] C_THRESHOLD = V_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PROC = 2'd2,
        S_FIRE = 2'd3
    } state_t;

    state_t               r_state;
    logic [V_WIDTH-1:0]   r_v;
    logic                 r_spike;
    logic                 r_flush;
    logic [N_SYN-1:0]     r_spk;
    logic [N_SYN-1:0]     r_ein;
    logic [SEL_W-1:0]     r_sel;
    logic [W_WIDTH-1:0]   r_weight [N_SYN];

    logic                 w_syn_active;
    logic [V_WIDTH-1:0]   w_weight;
    logic [V_WIDTH:0]     w_sum;
    logic [V_WIDTH-1:0]   w_v_next;
    logic [V_WIDTH-1:0]   w_v_leak;
    logic                 w_fire;

    // Synapse contributes only when its (optionally ST-gated) spike bit is set
    // and integration is not blocked by CT.
    assign w_syn_active = r_spk[r_sel] & (ST_and ? ST : 1'b1) & (CT_and ? CT : 1'b1);
    assign w_weight     = {{(V_WIDTH-W_WIDTH){1'b0}}, r_weight[r_sel]};
    assign w_sum        = {1'b0, r_v} + {1'b0, w_weight};
    assign w_v_next     = r_ein[r_sel]
                        ? (w_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : w_sum[V_WIDTH-1:0])
                        : ((r_v < w_weight) ? '0 : r_v - w_weight);
    assign w_v_leak     = (r_v < C_LEAK) ? '0 : r_v - C_LEAK;
    assign w_fire       = (w_v_leak >= C_THRESHOLD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_v     <= '0;
            r_spike <= 1'b0;
            r_flush <= 1'b0;
            r_spk   <= '0;
            r_ein   <= '0;
            r_sel   <= '0;
            for (int i = 0; i < N_SYN; i++) begin
                r_weight[i] <= W_WIDTH'(i);
            end
        end else begin
            r_spike <= 1'b0;
            r_flush <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_spk   <= parallel_spike_in;
                    r_ein   <= parallel_Ein;
                    r_sel   <= '0;
                    r_state <= S_PROC;
                end
                S_PROC: begin
                    if (w_syn_active) begin
                        r_v <= w_v_next;
                    end
                    if (r_sel == C_LAST) begin
                        r_sel   <= '0;
                        r_flush <= 1'b1;
                        r_state <= S_FIRE;
                    end else begin
                        r_sel <= r_sel + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (w_fire) begin
                        r_spike <= 1'b1;
                        r_v     <= '0;
                    end else begin
                        r_v <= w_v_leak;
                    end
                    r_state <= write ? S_LOAD : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign flush_weight = r_flush;
    assign flush_Ein    = r_flush;
    assign flush_spike  = r_flush;
    assign spike        = r_spike;
    assign select       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_synaptic_input_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_synaptic_input_processor
// Brief    : Sweep-level self-checking bench with directed table and random sweeps.
// Revision : 1.0
// ============================================================================
module tb_synaptic_input_processor;

    logic        clock = 1'b0;
    logic        reset;
    logic        write;
    logic        ST_and, CT_and, ST, CT;
    logic [15:0] parallel_spike_in, parallel_Ein;
    logic        flush_weight, flush_Ein, flush_spike, spike;
    logic [3:0]  select;

    int errors = 0;
    int checks = 0;
    int model_v = 0;

    synaptic_input_processor dut (
        .clock             (clock),
        .reset             (reset),
        .write             (write),
        .ST_and            (ST_and),
        .CT_and            (CT_and),
        .ST                (ST),
        .CT                (CT),
        .parallel_spike_in (parallel_spike_in),
        .parallel_Ein      (parallel_Ein),
        .flush_weight      (flush_weight),
        .flush_Ein         (flush_Ein),
        .flush_spike       (flush_spike),
        .spike             (spike),
        .select            (select)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int sel, input bit fl, input bit sp);
        chk({tag, " select"}, 32'(select), sel);
        chk({tag, " flush_weight"}, 32'(flush_weight), 32'(fl));
        chk({tag, " flush_Ein"}, 32'(flush_Ein), 32'(fl));
        chk({tag, " flush_spike"}, 32'(flush_spike), 32'(fl));
        chk({tag, " spike"}, 32'(spike), 32'(sp));
    endtask

    // Entry: at the falling edge inside a LOAD cycle. Exit: falling edge of
    // the cycle after FIRE (LOAD if wr_next, else IDLE).
    task automatic do_sweep(input logic [15:0] spk, input logic [15:0] ein,
                            input bit sta, input bit cta, input bit st, input bit ct,
                            input bit wr_next, input int drop_at, output bit got_spike);
        int  vl;
        bit  exp_sp;
        parallel_spike_in = spk;
        parallel_Ein      = ein;
        ST_and = sta; CT_and = cta; ST = st; CT = ct;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check_outs($sformatf("proc%0d", k), k, 1'b0, 1'b0);
            if (spk[k] && (sta ? st : 1'b1) && (cta ? ct : 1'b1)) begin
                if (ein[k]) model_v = (model_v + k > 255) ? 255 : model_v + k;
                else        model_v = (model_v < k) ? 0 : model_v - k;
            end
            if (k == drop_at) write = 1'b0;
        end
        @(negedge clock);
        check_outs("fire", 0, 1'b1, 1'b0);
        vl      = (model_v > 0) ? model_v - 1 : 0;
        exp_sp  = (vl >= 40);
        model_v = exp_sp ? 0 : vl;
        write   = wr_next;
        parallel_spike_in = 16'h0;
        parallel_Ein      = 16'h0;
        @(negedge clock);
        got_spike = spike;
        check_outs("post_fire", 0, 1'b0, exp_sp);
    endtask

    typedef struct {
        logic [15:0] spk;
        logic [15:0] ein;
        bit          sta, cta, st, ct;
        int          reps;
        bit          exp_spike;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit got;

        vecs[0] = '{16'hAAAA, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b1};
        vecs[1] = '{16'hD55D, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0};
        vecs[3] = '{16'hAAAA, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 14, 1'b0};
        vecs[4] = '{16'hAAAA, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1,  1'b1};

        reset = 1'b0; write = 1'b0;
        ST_and = 1'b0; CT_and = 1'b0; ST = 1'b0; CT = 1'b0;
        parallel_spike_in = 16'h0; parallel_Ein = 16'h0;
        #12;
        check_outs("reset", 0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        write = 1'b1;
        @(negedge clock);
        check_outs("load0", 0, 1'b0, 1'b0);

        // Directed sweeps
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                do_sweep(vecs[i].spk, vecs[i].ein, vecs[i].sta, vecs[i].cta,
                         vecs[i].st, vecs[i].ct, 1'b1, -1, got);
            end
            chk($sformatf("vec%0d spike", i), 32'(got), 32'(vecs[i].exp_spike));
        end

        // Random sweeps against the model
        for (int n = 0; n < 24; n++) begin
            do_sweep(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'b1, -1, got);
        end

        // write drops mid-sweep: sweep completes, then stays idle
        do_sweep(16'h00F0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, got);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check_outs($sformatf("idle%0d", c), 0, 1'b0, 1'b0);
        end
        write = 1'b1;
        @(negedge clock);
        check_outs("reload", 0, 1'b0, 1'b0);

        // Reset asserted in the middle of a sweep
        parallel_spike_in = 16'hFFFF; parallel_Ein = 16'hFFFF;
        ST_and = 1'b0; CT_and = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clock);
            check_outs($sformatf("pre_rst%0d", k), k, 1'b0, 1'b0);
        end
        #1 reset = 1'b0;
        #1 check_outs("mid_reset", 0, 1'b0, 1'b0);
        model_v = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outs("post_rst_load", 0, 1'b0, 1'b0);
        // A leftover potential of 36+ would push this small input over threshold
        do_sweep(16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, got);
        chk("post_reset spike", 32'(got), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
